// File: rtl/tdp_ram_be_if.sv
// Port bundle for tdp_ram_be: two symmetric access ports plus the collision flag.
// The master drives the access requests and the RAM (slave) returns read data and status.
interface tdp_ram_be_if #(
  parameter int MEM_WIDTH = 16,
  parameter int ADDR_SIZE = 10
);
  logic                   a_en;
  logic                   a_we;
  logic [MEM_WIDTH/8-1:0] a_be;
  logic [ADDR_SIZE-1:0]   a_addr;
  logic [MEM_WIDTH-1:0]   a_din;
  logic [MEM_WIDTH-1:0]   a_dout;
  logic                   a_valid;
  logic                   b_en;
  logic                   b_we;
  logic [MEM_WIDTH/8-1:0] b_be;
  logic [ADDR_SIZE-1:0]   b_addr;
  logic [MEM_WIDTH-1:0]   b_din;
  logic [MEM_WIDTH-1:0]   b_dout;
  logic                   b_valid;
  logic                   coll;

  modport master (
    output a_en, a_we, a_be, a_addr, a_din,
    output b_en, b_we, b_be, b_addr, b_din,
    input  a_dout, a_valid, b_dout, b_valid, coll
  );

  modport slave (
    input  a_en, a_we, a_be, a_addr, a_din,
    input  b_en, b_we, b_be, b_addr, b_din,
    output a_dout, a_valid, b_dout, b_valid, coll
  );
endinterface

// File: rtl/tdp_ram_be.sv
// True dual-port RAM with byte enables, selectable same-port read-during-write mode,
// optional output register, read-valid strobes and a registered address-collision flag.
module tdp_ram_be #(
  parameter int MEM_WIDTH = 16,
  parameter int MEM_DEPTH = 1024,
  parameter int ADDR_SIZE = 10,
  parameter int RD_MODE   = 0,
  parameter int OUT_REG   = 0
) (
  input logic         clk,
  input logic         rst,
  tdp_ram_be_if.slave bus
);
  localparam int unsigned NB = MEM_WIDTH / 8;
  localparam logic [ADDR_SIZE:0] DEPTH = (ADDR_SIZE + 1)'(MEM_DEPTH);

  logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];

  logic                 a_in, b_in, a_wr, b_wr;
  logic [MEM_WIDTH-1:0] a_rd, b_rd;
  logic [MEM_WIDTH-1:0] a_q, b_q;
  logic                 a_v, b_v, coll_q;

  always_comb begin
    a_in = ({1'b0, bus.a_addr} < DEPTH);
    b_in = ({1'b0, bus.b_addr} < DEPTH);
    a_wr = bus.a_en & bus.a_we & a_in;
    b_wr = bus.b_en & bus.b_we & b_in;
    a_rd = a_in ? mem[bus.a_addr] : '0;
    b_rd = b_in ? mem[bus.b_addr] : '0;
    // Write-first only merges the port's own bytes; the other port's write stays invisible.
    if (RD_MODE == 1) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (a_wr && bus.a_be[i]) a_rd[8*i +: 8] = bus.a_din[8*i +: 8];
        if (b_wr && bus.b_be[i]) b_rd[8*i +: 8] = bus.b_din[8*i +: 8];
      end
    end
  end

  // B is applied first so port A's bytes override on a same-address write-write collision.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NB; i++) begin
      if (b_wr && bus.b_be[i]) mem[bus.b_addr][8*i +: 8] <= bus.b_din[8*i +: 8];
      if (a_wr && bus.a_be[i]) mem[bus.a_addr][8*i +: 8] <= bus.a_din[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      a_v    <= 1'b0;
      b_v    <= 1'b0;
      coll_q <= 1'b0;
    end else begin
      a_v    <= bus.a_en;
      b_v    <= bus.b_en;
      coll_q <= bus.a_en & bus.b_en & (bus.a_addr == bus.b_addr) &
                ((bus.a_we & (|bus.a_be)) | (bus.b_we & (|bus.b_be)));
      if (bus.a_en) a_q <= a_rd;
      if (bus.b_en) b_q <= b_rd;
    end
  end

  assign bus.coll = coll_q;

  generate
    if (OUT_REG == 1) begin : g_out_reg
      logic [MEM_WIDTH-1:0] a_q2, b_q2;
      logic                 a_v2, b_v2;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q2 <= '0;
          b_q2 <= '0;
          a_v2 <= 1'b0;
          b_v2 <= 1'b0;
        end else begin
          a_v2 <= a_v;
          b_v2 <= b_v;
          if (a_v) a_q2 <= a_q;
          if (b_v) b_q2 <= b_q;
        end
      end

      assign bus.a_dout  = a_q2;
      assign bus.b_dout  = b_q2;
      assign bus.a_valid = a_v2;
      assign bus.b_valid = b_v2;
    end else begin : g_no_out_reg
      assign bus.a_dout  = a_q;
      assign bus.b_dout  = b_q;
      assign bus.a_valid = a_v;
      assign bus.b_valid = b_v;
    end
  endgenerate
endmodule

// File: tb/tb_tdp_ram_be.sv
// Bench for tdp_ram_be: two instances (read-first/no output reg/depth 1000 and
// write-first/output reg/depth 1024) driven identically and compared to a word-array model.
module tb_tdp_ram_be;
  localparam int W  = 16;
  localparam int AS = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          a_en = 0, a_we = 0, b_en = 0, b_we = 0;
  logic [1:0]    a_be = 0, b_be = 0;
  logic [AS-1:0] a_addr = 0, b_addr = 0;
  logic [W-1:0]  a_din = 0, b_din = 0;

  tdp_ram_be_if #(.MEM_WIDTH(W), .ADDR_SIZE(AS)) bus0 ();
  tdp_ram_be_if #(.MEM_WIDTH(W), .ADDR_SIZE(AS)) bus1 ();

  assign bus0.a_en = a_en;   assign bus1.a_en = a_en;
  assign bus0.a_we = a_we;   assign bus1.a_we = a_we;
  assign bus0.a_be = a_be;   assign bus1.a_be = a_be;
  assign bus0.a_addr = a_addr; assign bus1.a_addr = a_addr;
  assign bus0.a_din = a_din; assign bus1.a_din = a_din;
  assign bus0.b_en = b_en;   assign bus1.b_en = b_en;
  assign bus0.b_we = b_we;   assign bus1.b_we = b_we;
  assign bus0.b_be = b_be;   assign bus1.b_be = b_be;
  assign bus0.b_addr = b_addr; assign bus1.b_addr = b_addr;
  assign bus0.b_din = b_din; assign bus1.b_din = b_din;

  tdp_ram_be #(.MEM_WIDTH(W), .MEM_DEPTH(1000), .ADDR_SIZE(AS), .RD_MODE(0), .OUT_REG(0))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  tdp_ram_be #(.MEM_WIDTH(W), .MEM_DEPTH(1024), .ADDR_SIZE(AS), .RD_MODE(1), .OUT_REG(1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Reference model: one word array per instance plus a queue of scheduled read results per port.
  typedef struct {
    int          due;
    logic [15:0] data;
    bit          known;
  } exp_t;

  int unsigned depth_m [2] = '{1000, 1024};
  int          rdm_m   [2] = '{0, 1};
  int          lat_m   [2] = '{1, 2};
  logic [15:0] mem_m [2][1024];
  bit          wk_m  [2][1024];
  exp_t        expq [4][$];
  logic [15:0] hold [4];
  bit          hold_known [4];
  bit          coll_exp;
  int          cyc;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] din,
                                        input logic [1:0] be);
    logic [15:0] m;
    m = old;
    if (be[0]) m[7:0]  = din[7:0];
    if (be[1]) m[15:8] = din[15:8];
    return m;
  endfunction

  function automatic logic [15:0] get_dout(input int idx);
    case (idx)
      0: return bus0.a_dout;
      1: return bus0.b_dout;
      2: return bus1.a_dout;
      default: return bus1.b_dout;
    endcase
  endfunction

  function automatic logic get_valid(input int idx);
    case (idx)
      0: return bus0.a_valid;
      1: return bus0.b_valid;
      2: return bus1.a_valid;
      default: return bus1.b_valid;
    endcase
  endfunction

  task automatic model_edge();
    coll_exp = a_en && b_en && (a_addr == b_addr) &&
               ((a_we && a_be != 0) || (b_we && b_be != 0));
    for (int k = 0; k < 2; k++) begin
      bit          ain, bin;
      logic [15:0] va, vb, wa, wb;
      bit          ka, kb;
      exp_t        e;
      ain = int'(a_addr) < int'(depth_m[k]);
      bin = int'(b_addr) < int'(depth_m[k]);
      va = ain ? mem_m[k][a_addr] : 16'h0;
      vb = bin ? mem_m[k][b_addr] : 16'h0;
      ka = !ain || wk_m[k][a_addr];
      kb = !bin || wk_m[k][b_addr];
      if (rdm_m[k] == 1 && ain && a_we) begin
        va = merge(va, a_din, a_be);
        if (a_be == 2'b11) ka = 1;
      end
      if (rdm_m[k] == 1 && bin && b_we) begin
        vb = merge(vb, b_din, b_be);
        if (b_be == 2'b11) kb = 1;
      end
      if (a_en) begin
        e.due = cyc + lat_m[k] - 1; e.data = va; e.known = ka;
        expq[2*k].push_back(e);
      end
      if (b_en) begin
        e.due = cyc + lat_m[k] - 1; e.data = vb; e.known = kb;
        expq[2*k+1].push_back(e);
      end
      // Same-address write-write: A's bytes land on top of B's.
      if (b_en && b_we && bin) begin
        wb = merge(mem_m[k][b_addr], b_din, b_be);
        mem_m[k][b_addr] = wb;
        if (b_be == 2'b11) wk_m[k][b_addr] = 1;
      end
      if (a_en && a_we && ain) begin
        wa = merge(mem_m[k][a_addr], a_din, a_be);
        mem_m[k][a_addr] = wa;
        if (a_be == 2'b11) wk_m[k][a_addr] = 1;
      end
    end
  endtask

  task automatic check_outputs();
    for (int idx = 0; idx < 4; idx++) begin
      bit ev;
      ev = 0;
      if (expq[idx].size() > 0 && expq[idx][0].due == cyc) begin
        ev = 1;
        hold[idx]       = expq[idx][0].data;
        hold_known[idx] = expq[idx][0].known;
        void'(expq[idx].pop_front());
      end
      check($sformatf("valid%0d", idx), {31'b0, get_valid(idx)}, {31'b0, ev});
      if (hold_known[idx]) check($sformatf("dout%0d", idx), {16'b0, get_dout(idx)}, {16'b0, hold[idx]});
    end
    check("coll0", {31'b0, bus0.coll}, {31'b0, coll_exp});
    check("coll1", {31'b0, bus1.coll}, {31'b0, coll_exp});
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic set_a(input logic en, input logic we, input logic [1:0] be,
                       input int addr, input logic [15:0] din);
    a_en = en; a_we = we; a_be = be; a_addr = AS'(addr); a_din = din;
  endtask

  task automatic set_b(input logic en, input logic we, input logic [1:0] be,
                       input int addr, input logic [15:0] din);
    b_en = en; b_we = we; b_be = be; b_addr = AS'(addr); b_din = din;
  endtask

  task automatic idle();
    set_a(0, 0, 2'b00, 0, 16'h0);
    set_b(0, 0, 2'b00, 0, 16'h0);
  endtask

  task automatic apply_reset();
    idle();
    rst = 1'b1;
    #1;
    for (int idx = 0; idx < 4; idx++) begin
      check("rst_valid", {31'b0, get_valid(idx)}, 32'd0);
      check("rst_dout", {16'b0, get_dout(idx)}, 32'd0);
      expq[idx].delete();
      hold[idx] = 16'h0;
      hold_known[idx] = 1;
    end
    check("rst_coll0", {31'b0, bus0.coll}, 32'd0);
    check("rst_coll1", {31'b0, bus1.coll}, 32'd0);
    coll_exp = 0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst = 1'b0;
    check_outputs();
  endtask

  function automatic int rand_addr();
    int r;
    int pick [5] = '{0, 999, 1000, 1010, 1023};
    r = $urandom_range(0, 3);
    if (r < 2) return $urandom_range(0, 7);
    if (r == 2) return pick[$urandom_range(0, 4)];
    return $urandom_range(0, 1023);
  endfunction

  initial begin
    cyc = 0;
    coll_exp = 0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 1024; i++) begin
        mem_m[k][i] = 16'h0;
        wk_m[k][i]  = 0;
      end
    for (int idx = 0; idx < 4; idx++) begin
      hold[idx] = 16'h0;
      hold_known[idx] = 1;
    end
    rst = 1'b1;
    #12;
    rst = 1'b0;
    @(negedge clk);

    // Fill every word so later reads have defined contents.
    for (int i = 0; i < 512; i++) begin
      set_a(1, 1, 2'b11, 2 * i, 16'($urandom));
      set_b(1, 1, 2'b11, 2 * i + 1, 16'($urandom));
      step();
    end
    idle(); step(); step();

    // Latency: A writes, B reads the next cycle.
    set_a(1, 1, 2'b11, 5, 16'hBEEF); step();
    set_a(1, 1, 2'b11, 3, 16'h1234); step();
    idle(); set_b(1, 0, 2'b00, 3, 16'h0); step();
    idle(); step(); step();

    // Byte enables.
    set_a(1, 1, 2'b11, 7, 16'hAAAA); step();
    set_a(1, 1, 2'b01, 7, 16'h5555); step();
    idle(); set_b(1, 0, 2'b00, 7, 16'h0); step();
    idle(); step(); step();

    // Same-port read-during-write.
    set_a(1, 1, 2'b11, 9, 16'h1111); step();
    set_a(1, 1, 2'b11, 9, 16'h2222); step();
    idle(); step(); step();

    // Write-write and read-write collisions at the same address.
    set_a(1, 1, 2'b11, 4, 16'h0000); step();
    set_a(1, 1, 2'b11, 4, 16'hAAAA); set_b(1, 1, 2'b11, 4, 16'hBBBB); step();
    idle(); set_a(1, 0, 2'b00, 4, 16'h0); step();
    set_a(1, 1, 2'b01, 4, 16'hAAAA); set_b(1, 1, 2'b11, 4, 16'hBBBB); step();
    idle(); set_a(1, 0, 2'b00, 4, 16'h0); step();
    set_a(1, 1, 2'b11, 4, 16'hCCCC); set_b(1, 0, 2'b00, 4, 16'h0); step();
    set_a(1, 1, 2'b00, 4, 16'hDDDD); set_b(1, 0, 2'b00, 4, 16'h0); step();
    idle(); step(); step();

    // Boundaries, including an address beyond the smaller instance's depth.
    set_a(1, 1, 2'b11, 0, 16'h0F0F); set_b(1, 1, 2'b11, 999, 16'hF0F0); step();
    set_a(1, 1, 2'b11, 1023, 16'h7E7E); set_b(1, 1, 2'b11, 1010, 16'h5A5A); step();
    set_a(1, 0, 2'b00, 0, 16'h0); set_b(1, 0, 2'b00, 999, 16'h0); step();
    set_a(1, 0, 2'b00, 1023, 16'h0); set_b(1, 0, 2'b00, 1010, 16'h0); step();
    idle(); step(); step();

    // 16-cycle burst read on B.
    for (int i = 0; i < 16; i++) begin
      idle(); set_b(1, 0, 2'b00, 100 + i, 16'h0); step();
    end
    idle(); step(); step();

    // Reset with reads in flight, then confirm stored data survives.
    set_a(1, 0, 2'b00, 5, 16'h0); set_b(1, 0, 2'b00, 3, 16'h0); step();
    apply_reset();
    idle(); step(); step();
    set_a(1, 0, 2'b00, 5, 16'h0); step();
    idle(); step(); step();

    // Randomized traffic concentrated on a few addresses to provoke collisions.
    for (int n = 0; n < 3000; n++) begin
      set_a($urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
            rand_addr(), 16'($urandom));
      set_b($urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
            rand_addr(), 16'($urandom));
      step();
      if (n == 1500) apply_reset();
    end
    idle(); step(); step(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end
endmodule
